decode_fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 43 ++++
 rtl/dfq_storage.sv | 27 ++
 rtl/decode_fetch_queue.sv | 116 +++++++++++
 tb/tb_decode_fetch_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode bundle types and the lane packing helpers used on both sides
// of the fetch->decode interface.
package fetch_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned PC_WIDTH   = 16;
  localparam int unsigned LANE_BUS_W = LANES * PC_WIDTH;

  typedef struct packed {
    logic [LANES-1:0][PC_WIDTH-1:0] pc;
    logic [LANES-1:0][PC_WIDTH-1:0] inst;
    logic [LANES-1:0][PC_WIDTH-1:0] recv_pc;
    logic [LANES-1:0]               pred;
  } fetch_bundle_t;

  function automatic fetch_bundle_t pack_bundle(
    input logic [LANE_BUS_W-1:0] pc,
    input logic [LANE_BUS_W-1:0] inst,
    input logic [LANE_BUS_W-1:0] recv_pc,
    input logic [LANES-1:0]      pred
  );
    fetch_bundle_t b;
    b.pc      = pc;
    b.inst    = inst;
    b.recv_pc = recv_pc;
    b.pred    = pred;
    return b;
  endfunction

  function automatic void unpack_bundle(
    input  fetch_bundle_t         b,
    output logic [LANE_BUS_W-1:0] pc,
    output logic [LANE_BUS_W-1:0] inst,
    output logic [LANE_BUS_W-1:0] recv_pc,
    output logic [LANES-1:0]      pred
  );
    pc      = b.pc;
    inst    = b.inst;
    recv_pc = b.recv_pc;
    pred    = b.pred;
  endfunction

endpackage

// File: rtl/dfq_storage.sv
// Bundle register array for the decode fetch queue: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module dfq_storage
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  fetch_bundle_t     wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output fetch_bundle_t     rdata_o
);

  fetch_bundle_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/decode_fetch_queue.sv
// Decode-side FIFO for 4-wide fetch bundles with registered stall back-pressure
// and mispredict flush. Optional same-cycle bypass on an empty queue: DFQ_BYPASS_EN.
module decode_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_vld,
  input  logic [4*PC_WIDTH-1:0]       pc_to_dec,
  input  logic [4*PC_WIDTH-1:0]       inst_to_dec,
  input  logic [4*PC_WIDTH-1:0]       recv_pc_to_dec,
  input  logic [3:0]                  pred_result_to_dec,
  input  logic                        has_mispredict,
  input  logic                        dec_rdy,
  output logic                        stall_fetch,
  output logic                        dec_vld,
  output logic [4*PC_WIDTH-1:0]       dec_pc,
  output logic [4*PC_WIDTH-1:0]       dec_inst,
  output logic [4*PC_WIDTH-1:0]       dec_recv_pc,
  output logic [3:0]                  dec_pred,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;
  logic             ovf_q, ovf_d;

  logic             empty_c, full_c, bypass_c, pop_c, push_c;
  fetch_bundle_t    in_bundle_c, rd_bundle_c, head_c;

  assign in_bundle_c = pack_bundle(pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_result_to_dec);
  assign empty_c     = (count_q == '0);
  assign full_c      = (count_q == CNT_W'(DEPTH));

`ifdef DFQ_BYPASS_EN
  assign bypass_c = empty_c & fetch_vld & dec_rdy & ~has_mispredict;
`else
  assign bypass_c = 1'b0;
`endif

  // A pop frees the head slot at the same edge, so a full queue still accepts.
  assign pop_c  = ~empty_c & dec_rdy & ~has_mispredict;
  assign push_c = fetch_vld & ~has_mispredict & ~bypass_c & (~full_c | pop_c);

  dfq_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (push_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_bundle_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_bundle_c)
  );

  // Next-state for pointers, occupancy, stall and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    ovf_d    = ovf_q;
    if (has_mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      stall_d  = 1'b0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
      if (fetch_vld && full_c && !pop_c) ovf_d = 1'b1;
      stall_d = (count_d >= CNT_W'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  // Head data is forced to zero when nothing is valid so stale storage never leaks out.
  always_comb begin
    head_c = '0;
    if (!empty_c) head_c = rd_bundle_c;
    if (bypass_c) head_c = in_bundle_c;
    unpack_bundle(head_c, dec_pc, dec_inst, dec_recv_pc, dec_pred);
  end

  assign dec_vld     = ~empty_c | bypass_c;
  assign stall_fetch = stall_q;
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Randomised + directed scoreboard bench for decode_fetch_queue (DEPTH=4).
module tb_decode_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, fetch_vld, has_mispredict, dec_rdy;
  logic [63:0] pc_to_dec, inst_to_dec, recv_pc_to_dec;
  logic [3:0]  pred_result_to_dec;
  logic        stall_fetch, dec_vld, overflow;
  logic [63:0] dec_pc, dec_inst, dec_recv_pc;
  logic [3:0]  dec_pred;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  decode_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_vld          (fetch_vld),
    .pc_to_dec          (pc_to_dec),
    .inst_to_dec        (inst_to_dec),
    .recv_pc_to_dec     (recv_pc_to_dec),
    .pred_result_to_dec (pred_result_to_dec),
    .has_mispredict     (has_mispredict),
    .dec_rdy            (dec_rdy),
    .stall_fetch        (stall_fetch),
    .dec_vld            (dec_vld),
    .dec_pc             (dec_pc),
    .dec_inst           (dec_inst),
    .dec_recv_pc        (dec_recv_pc),
    .dec_pred           (dec_pred),
    .count              (count),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordinary queue of accepted bundles plus the two flags.
  fetch_bundle_t mq[$];
  bit            m_ovf   = 0;
  bit            m_stall = 0;
  bit            m_ok    = 0;
  bit            m_zero  = 0;

  // Monitor: compare outputs against the model mid-cycle, then advance the model
  // with the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    fetch_bundle_t inb, head;
    bit byp, exp_vld;
    inb = '{pc: pc_to_dec, inst: inst_to_dec, recv_pc: recv_pc_to_dec, pred: pred_result_to_dec};
    byp = 0;
`ifdef DFQ_BYPASS_EN
    byp = (mq.size() == 0) && fetch_vld && dec_rdy && !has_mispredict;
`endif
    if (m_ok) begin
      exp_vld = (mq.size() != 0) || byp;
      head    = byp ? inb : ((mq.size() != 0) ? mq[0] : '0);
      chk("dec_vld", 64'(dec_vld), 64'(exp_vld));
      chk("count", 64'(count), 64'(mq.size()));
      chk("stall_fetch", 64'(stall_fetch), 64'(m_stall));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (exp_vld) begin
        chk("dec_pc", dec_pc, 64'(head.pc));
        chk("dec_inst", dec_inst, 64'(head.inst));
        chk("dec_recv_pc", dec_recv_pc, 64'(head.recv_pc));
        chk("dec_pred", 64'(dec_pred), 64'(head.pred));
      end else if (m_zero) begin
        chk("reset_dec_pc_zero", dec_pc, 64'h0);
        chk("reset_dec_inst_zero", dec_inst, 64'h0);
      end
    end
    m_zero = 0;
    if (rst) begin
      mq.delete();
      m_ovf   = 0;
      m_stall = 0;
      m_ok    = 1;
      m_zero  = 1;
    end else if (m_ok) begin
      if (has_mispredict) begin
        mq.delete();
        m_stall = 0;
      end else begin
        if (!byp) begin
          if (mq.size() != 0 && dec_rdy) void'(mq.pop_front());
          if (fetch_vld) begin
            if (mq.size() < DEPTH) mq.push_back(inb);
            else m_ovf = 1;
          end
        end
        m_stall = (mq.size() >= DEPTH - 1);
      end
    end
  end

  function automatic fetch_bundle_t rand_bundle();
    fetch_bundle_t b;
    for (int l = 0; l < LANES; l++) begin
      b.pc[l]      = 16'($urandom);
      b.inst[l]    = 16'($urandom);
      b.recv_pc[l] = 16'($urandom);
    end
    b.pred = 4'($urandom);
    return b;
  endfunction

  task automatic drive(input logic fv, input logic rdy, input logic mp, input logic r,
                       input fetch_bundle_t b);
    @(posedge clk);
    #1;
    fetch_vld          = fv;
    dec_rdy            = rdy;
    has_mispredict     = mp;
    rst                = r;
    pc_to_dec          = b.pc;
    inst_to_dec        = b.inst;
    recv_pc_to_dec     = b.recv_pc;
    pred_result_to_dec = b.pred;
  endtask

  initial begin
    fetch_bundle_t b;
    rst = 1; fetch_vld = 0; dec_rdy = 0; has_mispredict = 0;
    pc_to_dec = '0; inst_to_dec = '0; recv_pc_to_dec = '0; pred_result_to_dec = '0;

    drive(0, 0, 0, 1, '0);
    drive(0, 0, 0, 0, '0);

    // Single bundle pc 0x10..0x13 with the decoder ready.
    for (int l = 0; l < LANES; l++) begin
      b.pc[l]      = 16'h0010 + 16'(l);
      b.inst[l]    = 16'h1234 + 16'(l);
      b.recv_pc[l] = 16'h0000;
    end
    b.pred = 4'b0101;
    drive(1, 1, 0, 0, b);
    drive(0, 1, 0, 0, '0);
    drive(0, 1, 0, 0, '0);

    // Fill with decoder stalled: stall after 3rd, full after 4th, 5th dropped.
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, rand_bundle());
    drive(0, 0, 0, 0, '0);

    // Full queue streaming: push and pop together through pointer wrap.
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, rand_bundle());
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, '0);

    // Flush at count 3 with a concurrent fetch, then a new head.
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, rand_bundle());
    drive(1, 0, 1, 0, rand_bundle());
    drive(1, 0, 0, 0, rand_bundle());
    drive(0, 1, 0, 0, '0);
    drive(0, 1, 0, 0, '0);

    // Reset mid-stream at count 2 while overflow is still set.
    drive(1, 0, 0, 0, rand_bundle());
    drive(1, 0, 0, 0, rand_bundle());
    drive(0, 0, 0, 1, '0);
    drive(0, 0, 0, 0, '0);

    // Empty queue, lane0 pc 0x0040 with the decoder ready (same-cycle under bypass).
    b = rand_bundle();
    b.pc[0] = 16'h0040;
    drive(1, 1, 0, 0, b);
    drive(0, 1, 0, 0, '0);

    // Randomised traffic including zero lanes, flushes and rare resets.
    for (int i = 0; i < 3000; i++) begin
      b = rand_bundle();
      if ($urandom_range(0, 15) == 0) b.pc = '0;
      drive(logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 9) < 5),
            logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 299) == 0), b);
    end
    drive(0, 1, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
